reg_bank: RTL

//  Parametrised general-purpose register bank that replaces the eight discrete 8-bit registers in the CPU core.
//  - Two registered read ports feed the data bus / ALU.
//  - One write port.
//  - One pointer-pair port: even register = high byte, odd register = low byte; drives the address bus.
//  - Pair post-increment / decrement / load, so the control unit can step pointers without bus cycles.

---
 rtl/reg_bank_pkg.sv | 21 ++
 rtl/reg_bank_if.sv | 51 +++++
 rtl/reg_bank_pair_incdec.sv | 34 +++
 rtl/reg_bank.sv | 116 +++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared constants for the CPU general-purpose register bank.
//   pair_op_e   : pair operation codes driven on pair_op
//   DEF_WIDTH   : default register width in bits
//   DEF_NREGS   : default number of registers
// No ports (package).
// -----------------------------------------------------------------------------
package reg_bank_pkg;

  typedef enum logic [1:0] {
    PAIR_NONE = 2'b00,
    PAIR_INC  = 2'b01,
    PAIR_DEC  = 2'b10,
    PAIR_LOAD = 2'b11
  } pair_op_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREGS = 8;

endpackage

// File: rtl/reg_bank_if.sv
// -----------------------------------------------------------------------------
// reg_bank_if
// Bundles the read, write and pointer-pair signals of the register bank.
// Parameters: NREGS (register count), WIDTH (register width).
// Signals:
//   rd_a_addr/rd_b_addr  read indices            (master -> slave)
//   rd_a_data/rd_b_data  registered read data    (slave -> master)
//   wr_en/wr_addr/wr_data byte write port        (master -> slave)
//   pair_sel/pair_op/pair_wdata pair operation   (master -> slave)
//   pair_addr            selected pair contents  (slave -> master)
//   pair_carry           inc/dec wrapped         (slave -> master)
//   wr_conflict          byte write was dropped  (slave -> master)
// Modports: master (control unit side), slave (reg_bank side).
// -----------------------------------------------------------------------------
interface reg_bank_if
  import reg_bank_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int WIDTH = DEF_WIDTH
) ();

  localparam int AW = $clog2(NREGS);
  localparam int PW = (AW > 1) ? AW - 1 : 1;

  logic [AW-1:0]      rd_a_addr;
  logic [WIDTH-1:0]   rd_a_data;
  logic [AW-1:0]      rd_b_addr;
  logic [WIDTH-1:0]   rd_b_data;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [PW-1:0]      pair_sel;
  logic [1:0]         pair_op;
  logic [2*WIDTH-1:0] pair_wdata;
  logic [2*WIDTH-1:0] pair_addr;
  logic               pair_carry;
  logic               wr_conflict;

  modport master (
    output rd_a_addr, rd_b_addr, wr_en, wr_addr, wr_data,
           pair_sel, pair_op, pair_wdata,
    input  rd_a_data, rd_b_data, pair_addr, pair_carry, wr_conflict
  );

  modport slave (
    input  rd_a_addr, rd_b_addr, wr_en, wr_addr, wr_data,
           pair_sel, pair_op, pair_wdata,
    output rd_a_data, rd_b_data, pair_addr, pair_carry, wr_conflict
  );

endinterface

// File: rtl/reg_bank_pair_incdec.sv
// -----------------------------------------------------------------------------
// pair_incdec
// Combinational +1 / -1 on a 2*WIDTH-bit register pair with wrap detection.
// Ports:
//   value  in  2*WIDTH  current pair contents {high, low}
//   dec    in  1        0 = increment, 1 = decrement
//   result out 2*WIDTH  value +/- 1, modulo 2^(2*WIDTH)
//   wrap   out 1        increment from all-ones or decrement from zero
// -----------------------------------------------------------------------------
module pair_incdec
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] value,
  input  logic               dec,
  output logic [2*WIDTH-1:0] result,
  output logic               wrap
);

  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Full-width add/sub so the low byte's carry/borrow reaches the high byte.
  always_comb begin
    if (dec) begin
      result = value - ONE;
      wrap   = (value == '0);
    end else begin
      result = value + ONE;
      wrap   = &value;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank
// General-purpose register bank with two registered read ports, one byte
// write port and a pointer-pair port (even reg = high byte, odd = low byte)
// supporting increment, decrement and load.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   bus   reg_bank_if.slave (read/write/pair signals, see reg_bank_if)
// Configuration macro:
//   REG_BANK_BYPASS_EN  defined   -> read ports are write-first
//                       undefined -> read ports are read-before-write
// -----------------------------------------------------------------------------
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  reg_bank_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("reg_bank: NREGS must be a power of two and at least 2");
  end

  logic [WIDTH-1:0]   regs      [NREGS];
  logic [WIDTH-1:0]   regs_next [NREGS];
  logic [AW-1:0]      hi_idx;
  logic [AW-1:0]      lo_idx;
  logic [2*WIDTH-1:0] pair_cur;
  logic [2*WIDTH-1:0] pair_next;
  logic [2*WIDTH-1:0] step_result;
  logic               step_wrap;
  logic               pair_active;
  logic               pair_step;
  logic               conflict;
  logic [WIDTH-1:0]   rd_a_src;
  logic [WIDTH-1:0]   rd_b_src;

  // The size cast also covers NREGS=2, where the single pair has index 0.
  assign hi_idx   = AW'({bus.pair_sel, 1'b0});
  assign lo_idx   = hi_idx | AW'(1);
  assign pair_cur = {regs[hi_idx], regs[lo_idx]};

  assign bus.pair_addr = pair_cur;

  assign pair_active = (bus.pair_op != PAIR_NONE);
  assign pair_step   = (bus.pair_op == PAIR_INC) || (bus.pair_op == PAIR_DEC);

  // A byte write lands inside the selected pair when both indices share the
  // same pair number, i.e. they agree after forcing bit 0 high.
  assign conflict = bus.wr_en && pair_active &&
                    ((bus.wr_addr | AW'(1)) == lo_idx);

  pair_incdec #(.WIDTH(WIDTH)) u_incdec (
    .value  (pair_cur),
    .dec    (bus.pair_op == PAIR_DEC),
    .result (step_result),
    .wrap   (step_wrap)
  );

  always_comb begin
    pair_next = pair_cur;
    unique case (bus.pair_op)
      PAIR_INC, PAIR_DEC: pair_next = step_result;
      PAIR_LOAD:          pair_next = bus.pair_wdata;
      default:            pair_next = pair_cur;
    endcase
  end

  // Next contents of the whole array: byte write first, then the pair op, so
  // the pair op takes priority whenever both hit the same register.
  always_comb begin
    regs_next = regs;
    if (bus.wr_en && !conflict) begin
      regs_next[bus.wr_addr] = bus.wr_data;
    end
    if (pair_active) begin
      regs_next[hi_idx] = pair_next[2*WIDTH-1:WIDTH];
      regs_next[lo_idx] = pair_next[WIDTH-1:0];
    end
  end

`ifdef REG_BANK_BYPASS_EN
  // Write-first: read what the register will hold after this edge.
  assign rd_a_src = regs_next[bus.rd_a_addr];
  assign rd_b_src = regs_next[bus.rd_b_addr];
`else
  assign rd_a_src = regs[bus.rd_a_addr];
  assign rd_b_src = regs[bus.rd_b_addr];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      bus.rd_a_data   <= '0;
      bus.rd_b_data   <= '0;
      bus.pair_carry  <= 1'b0;
      bus.wr_conflict <= 1'b0;
    end else begin
      regs            <= regs_next;
      bus.rd_a_data   <= rd_a_src;
      bus.rd_b_data   <= rd_b_src;
      bus.pair_carry  <= pair_step && step_wrap;
      bus.wr_conflict <= conflict;
    end
  end

endmodule
